lcd_reader: RTL
===============

LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter T_SETUP, default 2, sets the RS/RW-to-EN setup time in clk cycles (minimum 1).
REQ-002 Parameter T_EN, default 25, sets the EN high width in clk cycles (minimum 1).
REQ-003 Parameter T_HOLD, default 25, sets the EN-low hold/recovery time in clk cycles (minimum 1).
REQ-004 Parameter MAX_POLLS, default 255, sets the maximum status reads per poll request (minimum 1).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 req  in  1  read request; accepted only on a cycle where req=1 and ready=1.
REQ-008 req_rs  in  1  register select captured at accept: 0 = status (busy flag/address), 1 = data RAM.
REQ-009 poll  in  1  captured at accept; with req_rs=0, repeat status reads until busy=0.
REQ-010 ready  out  1  high only in IDLE.
REQ-011 rd_data  out  8  last completed read byte, held until the next completion.
REQ-012 rd_valid  out  1  one-cycle completion pulse.
REQ-013 busy_flag  out  1  bit 7 of the last status read.
REQ-014 addr  out  7  bits 6:0 of the last status read.
REQ-015 timeout  out  1  set with rd_valid when a poll ends with busy still 1; cleared at the next accept.
REQ-016 lcd_data_in  in  8  LCD data bus input; this block never drives the bus.
REQ-017 EN, RW, RS  out  1 each  LCD strobe, read/write select, register select.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP, STROBE and HOLD, with one 16-bit down-counter shared between them.
REQ-019 IDLE: EN=0, RW=0, RS=0, ready=1; on accept, latch req_rs and poll, clear the poll count, load the counter with T_SETUP-1, and go to SETUP.
REQ-020 SETUP: RW=1, RS=latched req_rs, EN=0; at count 0, load T_EN-1 and go to STROBE.
REQ-021 STROBE: EN=1, with RW and RS held; at count 0, sample lcd_data_in, load T_HOLD-1, and go to HOLD.
REQ-022 HOLD: EN=0, with RW and RS held; at count 0, apply REQ-024 to choose the next state.
REQ-023 Register updates on the sample edge:
  - req_rs=0: update busy_flag and addr.
  - req_rs=1: leave busy_flag and addr unchanged.
REQ-024 HOLD exit:
  - poll=1, req_rs=0, sampled bit7=1 and poll count+1 < MAX_POLLS: increment the poll count, go to SETUP (no IDLE visit), no rd_valid.
  - Any other case: go to IDLE.
REQ-025 rd_valid SHALL pulse on the first HOLD cycle of the final read only.
  - rd_data updates with the sampled byte on that same cycle.
  - timeout=1 on that cycle if the final sample had bit7=1 and poll=1.
REQ-026 Latency: accept at cycle 0 -> rd_valid at cycle T_SETUP+T_EN+1 -> ready at cycle T_SETUP+T_EN+T_HOLD+1.
REQ-027 req while ready=0 SHALL be ignored and not queued; req_rs and poll changes mid-transaction SHALL have no effect.
REQ-028 poll=1 with req_rs=1 SHALL perform a single data read.
REQ-029 EN SHALL never be high while RW=0, and RS/RW SHALL not change while EN=1.

Reset
REQ-030 rst low SHALL immediately force state IDLE, EN=0, RW=0, RS=0, ready=1, rd_valid=0, rd_data=0, busy_flag=0, addr=0, timeout=0, counter=0 and poll count=0, including mid-STROBE.
REQ-031 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification (T_SETUP=2, T_EN=4, T_HOLD=3, MAX_POLLS=3)
REQ-032 Data read: req=1, req_rs=1, lcd_data_in=8'h41 -> RW=1 on cycles 1-9, EN=1 on cycles 3-6, rd_valid at cycle 7 with rd_data=8'h41, ready at cycle 10, busy_flag and addr unchanged.
REQ-033 Status read: req_rs=0, poll=0, bus=8'h85 -> rd_data=8'h85, busy_flag=1, addr=7'h05, timeout=0.
REQ-034 Poll success: req_rs=0, poll=1, bus=8'h80 for the first two samples then 8'h12 -> three EN pulses, exactly one rd_valid with busy_flag=0 and addr=7'h12.
REQ-035 Poll timeout: bus stuck at 8'hFF, poll=1 -> three EN pulses, then rd_valid with timeout=1 and busy_flag=1, then IDLE.
REQ-036 Reset mid-STROBE: rst low at cycle 4 -> EN=0 and RW=0 the same cycle, no rd_valid; after release, a new req completes per REQ-026.
REQ-037 Busy ignore: a second req pulse at cycle 5 -> no second transaction; exactly one rd_valid.

Source files
------------

// File: rtl/lcd_reader.sv
// HD44780-style LCD bus reader: status/data reads with optional busy-flag polling.
// Accept -> rd_valid after T_SETUP+T_EN+1 cycles per read; ready (accept) only in IDLE, no queuing.
module lcd_reader #(
  parameter int T_SETUP   = 2,
  parameter int T_EN      = 25,
  parameter int T_HOLD    = 25,
  parameter int MAX_POLLS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_rs,
  input  logic       poll,
  output logic       ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy_flag,
  output logic [6:0] addr,
  output logic       timeout,
  input  logic [7:0] lcd_data_in,
  output logic       EN,
  output logic       RW,
  output logic       RS
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [15:0] LD_SETUP = 16'(T_SETUP - 1);
  localparam logic [15:0] LD_EN    = 16'(T_EN - 1);
  localparam logic [15:0] LD_HOLD  = 16'(T_HOLD - 1);
  localparam logic [31:0] MAX_P    = 32'(MAX_POLLS);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] poll_cnt, poll_cnt_nxt;
  logic        rs_q, poll_q, again_q;
  logic        accept, cnt_zero, sample, again;

  assign accept   = req && (state == IDLE);
  assign cnt_zero = (cnt == 16'd0);
  assign sample   = (state == STROBE) && cnt_zero;

  // Another status read is needed only while polling, still busy, and under the poll budget.
  assign again = poll_q && !rs_q && lcd_data_in[7] &&
                 ((32'(poll_cnt) + 32'd1) < MAX_P);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      poll_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      poll_cnt <= poll_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    poll_cnt_nxt = poll_cnt;
    ready        = 1'b0;
    EN           = 1'b0;
    RW           = 1'b0;
    RS           = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          state_nxt    = SETUP;
          cnt_nxt      = LD_SETUP;
          poll_cnt_nxt = 16'd0;
        end
      end
      SETUP: begin
        RW = 1'b1;
        RS = rs_q;
        if (cnt_zero) begin
          state_nxt = STROBE;
          cnt_nxt   = LD_EN;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      STROBE: begin
        EN = 1'b1;
        RW = 1'b1;
        RS = rs_q;
        if (cnt_zero) begin
          state_nxt = HOLD;
          cnt_nxt   = LD_HOLD;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      HOLD: begin
        RW = 1'b1;
        RS = rs_q;
        if (cnt_zero) begin
          if (again_q) begin
            state_nxt    = SETUP;
            cnt_nxt      = LD_SETUP;
            poll_cnt_nxt = poll_cnt + 16'd1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Completion is decided at the sample edge so rd_valid lands on the first HOLD cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      again_q   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'd0;
      busy_flag <= 1'b0;
      addr      <= 7'd0;
      timeout   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        rs_q    <= req_rs;
        poll_q  <= poll;
        again_q <= 1'b0;
        timeout <= 1'b0;
      end
      if (sample) begin
        again_q <= again;
        if (!rs_q) begin
          busy_flag <= lcd_data_in[7];
          addr      <= lcd_data_in[6:0];
        end
        if (!again) begin
          rd_valid <= 1'b1;
          rd_data  <= lcd_data_in;
          timeout  <= lcd_data_in[7] && poll_q && !rs_q;
        end
      end
    end
  end

endmodule
